// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIfetch,
    StDacc,
    StIret,
    StDret
  } arb_state_e;

  localparam int unsigned TimeoutDefault = 15;

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Wait-cycle counter for an outstanding memory request; flags the last permitted cycle.
module mem_wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LastCount = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Expiry is asserted in the cycle whose increment would reach TIMEOUT.
  assign o_expired = i_en & (r_count == LastCount);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and MEM-stage accesses onto one req/ack memory port with timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_stall,
  input  logic          i_lw_mem,
  input  logic          i_sw_mem,
  input  logic [AW-1:0] i_mem_addr,
  input  logic [DW-1:0] i_mem_wdata,
  output logic [DW-1:0] o_mem_rdata,
  output logic          o_mem_stall,
  output logic          o_mreq,
  output logic          o_mwe,
  output logic [AW-1:0] o_maddr,
  output logic [DW-1:0] o_mwdata,
  input  logic [DW-1:0] i_mrdata,
  input  logic          i_mack,
  output logic          o_err
);

  arb_state_e    r_state, w_state_next;
  logic          r_mreq, w_mreq_next;
  logic          r_mwe, w_mwe_next;
  logic [AW-1:0] r_maddr, w_maddr_next;
  logic [DW-1:0] r_mwdata, w_mwdata_next;
  logic [DW-1:0] r_if_rdata, w_if_rdata_next;
  logic [DW-1:0] r_mem_rdata, w_mem_rdata_next;
  logic          r_err, w_err_next;

  logic w_data_req;
  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_tmr_expired;

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_expired(w_tmr_expired)
  );

  assign w_data_req  = i_lw_mem | i_sw_mem;
  assign o_mem_stall = w_data_req & (r_state != StDret);
  assign o_if_stall  = (i_if_req & (r_state != StIret)) | o_mem_stall;

  always_comb begin
    w_state_next     = r_state;
    w_mreq_next      = r_mreq;
    w_mwe_next       = r_mwe;
    w_maddr_next     = r_maddr;
    w_mwdata_next    = r_mwdata;
    w_if_rdata_next  = r_if_rdata;
    w_mem_rdata_next = r_mem_rdata;
    w_err_next       = r_err | (i_lw_mem & i_sw_mem);
    w_tmr_clr        = 1'b0;
    w_tmr_en         = 1'b0;

    unique case (r_state)
      StIdle: begin
        // The MEM-stage instruction is older, so it wins over fetch.
        if (w_data_req) begin
          w_state_next  = StDacc;
          w_mreq_next   = 1'b1;
          w_mwe_next    = i_sw_mem;
          w_maddr_next  = i_mem_addr;
          w_mwdata_next = i_mem_wdata;
          w_tmr_clr     = 1'b1;
        end else if (i_if_req) begin
          w_state_next = StIfetch;
          w_mreq_next  = 1'b1;
          w_mwe_next   = 1'b0;
          w_maddr_next = i_if_addr;
          w_tmr_clr    = 1'b1;
        end
      end
      StIfetch: begin
        w_tmr_en = 1'b1;
        if (i_mack) begin
          w_if_rdata_next = i_mrdata;
          w_mreq_next     = 1'b0;
          w_state_next    = StIret;
        end else if (w_tmr_expired) begin
          w_if_rdata_next = '0;
          w_mreq_next     = 1'b0;
          w_err_next      = 1'b1;
          w_state_next    = StIret;
        end
      end
      StDacc: begin
        w_tmr_en = 1'b1;
        if (i_mack) begin
          if (!r_mwe) w_mem_rdata_next = i_mrdata;
          w_mreq_next  = 1'b0;
          w_state_next = StDret;
        end else if (w_tmr_expired) begin
          if (!r_mwe) w_mem_rdata_next = '0;
          w_mreq_next  = 1'b0;
          w_err_next   = 1'b1;
          w_state_next = StDret;
        end
      end
      StIret, StDret: w_state_next = StIdle;
      default:        w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StIdle;
      r_mreq      <= 1'b0;
      r_mwe       <= 1'b0;
      r_maddr     <= '0;
      r_mwdata    <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mreq      <= w_mreq_next;
      r_mwe       <= w_mwe_next;
      r_maddr     <= w_maddr_next;
      r_mwdata    <= w_mwdata_next;
      r_if_rdata  <= w_if_rdata_next;
      r_mem_rdata <= w_mem_rdata_next;
      r_err       <= w_err_next;
    end
  end

  assign o_mreq      = r_mreq;
  assign o_mwe       = r_mwe;
  assign o_maddr     = r_maddr;
  assign o_mwdata    = r_mwdata;
  assign o_if_rdata  = r_if_rdata;
  assign o_mem_rdata = r_mem_rdata;
  assign o_err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic          clk;
  logic          reset_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_stall;
  logic          lw_mem;
  logic          sw_mem;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_stall;
  logic          mreq;
  logic          mwe;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata;
  logic [DW-1:0] mrdata;
  logic          mack;
  logic          err;

  mem_port_arbiter #(
    .AW(AW),
    .DW(DW),
    .TIMEOUT(TO)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_rdata (if_rdata),
    .o_if_stall (if_stall),
    .i_lw_mem   (lw_mem),
    .i_sw_mem   (sw_mem),
    .i_mem_addr (mem_addr),
    .i_mem_wdata(mem_wdata),
    .o_mem_rdata(mem_rdata),
    .o_mem_stall(mem_stall),
    .o_mreq     (mreq),
    .o_mwe      (mwe),
    .o_maddr    (maddr),
    .o_mwdata   (mwdata),
    .i_mrdata   (mrdata),
    .i_mack     (mack),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level view of the architecturally visible registers.
  logic [DW-1:0] m_if_rdata  = '0;
  logic [DW-1:0] m_mem_rdata = '0;
  logic          m_err       = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    tick();
    if_req = 1'b0;
    lw_mem = 1'b0;
    sw_mem = 1'b0;
    mack   = 1'b0;
    mrdata = $urandom;
    #1;
    chk("idle_mreq", mreq, 0);
    chk("idle_mem_stall", mem_stall, 0);
    chk("idle_if_stall", if_stall, 0);
  endtask

  // kind: 0 fetch, 1 load, 2 store, 3 load+store. ack_k: cycle of mack after grant (0 = never).
  task automatic access(input int kind, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int ack_k, input logic [DW-1:0] rdata, input bit hold_if);
    bit is_data  = (kind != 0);
    bit is_store = (kind >= 2);
    bit hit      = (ack_k >= 1) && (ack_k <= TO);
    int e        = hit ? ack_k : TO;

    tick();
    if_req = (kind == 0) || hold_if;
    lw_mem = (kind == 1) || (kind == 3);
    sw_mem = is_store;
    if (kind == 0) if_addr = addr;
    else mem_addr = addr;
    mem_wdata = wdata;
    mack      = 1'b0;
    mrdata    = $urandom;
    #1;
    chk("grant_mreq", mreq, 0);
    chk("grant_mem_stall", mem_stall, is_data);
    chk("grant_if_stall", if_stall, 1);

    for (int c = 1; c <= e; c++) begin
      tick();
      mack   = (c == ack_k);
      mrdata = (c == ack_k) ? rdata : DW'($urandom);
      #1;
      chk("wait_mreq", mreq, 1);
      chk("wait_mwe", mwe, is_store);
      chk("wait_maddr", maddr, addr);
      if (is_store) chk("wait_mwdata", mwdata, wdata);
      chk("wait_mem_stall", mem_stall, is_data);
      chk("wait_if_stall", if_stall, 1);
    end

    if (kind == 0) m_if_rdata = hit ? rdata : '0;
    else if (!is_store) m_mem_rdata = hit ? rdata : '0;
    if (!hit || kind == 3) m_err = 1'b1;

    // Release cycle; a late ack here must be ignored.
    tick();
    mack   = (ack_k == e + 1);
    mrdata = $urandom;
    #1;
    chk("ret_mreq", mreq, 0);
    chk("ret_mem_stall", mem_stall, 0);
    chk("ret_if_stall", if_stall, is_data ? hold_if : 1'b0);
    chk("ret_if_rdata", if_rdata, m_if_rdata);
    chk("ret_mem_rdata", mem_rdata, m_mem_rdata);
    chk("ret_err", err, m_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    lw_mem    = 1'b0;
    sw_mem    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mrdata    = '0;
    mack      = 1'b0;
    #12;
    chk("rst_mreq", mreq, 0);
    chk("rst_mwe", mwe, 0);
    chk("rst_maddr", maddr, 0);
    chk("rst_mwdata", mwdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_stalls", {if_stall, mem_stall}, 0);
    reset_n = 1'b1;
    idle_cycle();

    // Load with ack in cycle 3, then store with immediate ack.
    access(1, 32'h40, 32'h0, 3, 32'hDEADBEEF, 1'b0);
    idle_cycle();
    access(2, 32'h80, 32'h12345678, 1, 32'hCAFEF00D, 1'b0);
    idle_cycle();

    // Fetch and load together: load first, fetch granted from the following IDLE.
    access(1, 32'h100, 32'h0, 2, 32'hA5A5A5A5, 1'b1);
    access(0, 32'h200, 32'h0, 1, 32'h00C0FFEE, 1'b0);
    idle_cycle();

    // Ack exactly in the timeout cycle still succeeds.
    access(1, 32'h44, 32'h0, TO, 32'h11112222, 1'b0);
    idle_cycle();

    // Timeout with no ack, then err persists across a good access.
    access(1, 32'h48, 32'h0, 0, 32'h0, 1'b0);
    idle_cycle();
    chk("err_sticky", err, 1);
    access(0, 32'h204, 32'h0, 2, 32'h33334444, 1'b0);
    idle_cycle();

    access(3, 32'hC0, 32'h55667788, 2, 32'h0, 1'b0);
    idle_cycle();

    for (int i = 0; i < 40; i++) begin
      int kind = $urandom_range(0, 2);
      int ack;
      int r = $urandom_range(0, 9);
      if (kind == 2) ack = $urandom_range(1, 4);
      else ack = (r < 8) ? $urandom_range(1, 5) : $urandom_range(TO, TO + 1);
      access(kind, AW'($urandom), DW'($urandom), ack, DW'($urandom), $urandom_range(0, 1) == 1);
      for (int j = $urandom_range(0, 1); j > 0; j--) idle_cycle();
    end

    // Asynchronous reset while a load waits.
    tick();
    lw_mem   = 1'b1;
    mem_addr = 32'h1234;
    #1;
    tick();
    #1;
    chk("pre_rst_mreq", mreq, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_mreq", mreq, 0);
    chk("arst_maddr", maddr, 0);
    chk("arst_mwe", mwe, 0);
    chk("arst_mwdata", mwdata, 0);
    chk("arst_if_rdata", if_rdata, 0);
    chk("arst_mem_rdata", mem_rdata, 0);
    chk("arst_err", err, 0);
    lw_mem = 1'b0;
    m_if_rdata  = '0;
    m_mem_rdata = '0;
    m_err       = 1'b0;
    tick();
    reset_n = 1'b1;
    idle_cycle();
    access(1, 32'h60, 32'h0, 1, 32'h76543210, 1'b0);
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
